// File: rtl/ctmm_pkg.sv
// Shared capability-machine types used by the SWITCH sequencer and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctmm_pkg;

    // Fault classes reported by the sequencer and by mLoad.
    typedef enum logic [2:0] {
        FAULT_NONE   = 3'd0,
        FAULT_PERM   = 3'd1,
        FAULT_BOUNDS = 3'd2,
        FAULT_TYPE   = 3'd3,
        FAULT_SEAL   = 3'd4
    } fault_type_t;

    // Bit position of the L (load) permission inside the permission byte at word0_gt[48 +: 8].
    localparam int PERM_L = 2;

    // Capability register as seen on the register-file read port.
    typedef struct packed {
        logic [63:0] word0_gt;
        logic [31:0] word1;
    } capability_reg_t;

endpackage

// File: rtl/ctmm_switch_gen.sv
// SWITCH sequencer: validates source C-List register and L permission, snapshots the old destination, then drives mLoad.
// Latency: start sampled in cycle 0, sub_start from cycle 4 (cycle 5 with SAVE_PREV); done reported in the cycle sub_done arrives.
// Backpressure: switch_start is ignored while busy (start_dropped pulses); sub_start is held until mLoad raises sub_busy.
module ctmm_switch_gen
    import ctmm_pkg::*;
#(
    parameter int                        NUM_SRC_CR     = 8,
    parameter int                        TARGET_W       = 3,
    parameter int                        DEST_BASE      = 8,
    parameter logic [2**TARGET_W-1:0]    TARGET_EN_MASK = 8'hFF,
    parameter int                        INDEX_W        = 10,
    parameter bit                        SAVE_PREV      = 1'b1,
    parameter int                        TIMEOUT_CYC    = 1024,
    parameter fault_type_t               TIMEOUT_FAULT  = FAULT_PERM
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                switch_start,
    input  logic [3:0]          cr_src,
    input  logic [TARGET_W-1:0] target,
    input  logic [INDEX_W-1:0]  index,
    output logic                switch_busy,
    output logic                switch_complete,
    output logic                switch_fault,
    output fault_type_t         fault_type,
    output logic [2:0]          fault_cause,
    output logic                start_dropped,
    output logic [3:0]          cr_rd_addr,
    input  capability_reg_t     cr_rd_data,
    output capability_reg_t     prev_cap,
    output logic                prev_valid,
    output logic                sub_start,
    output logic [3:0]          sub_cr_src,
    output logic [3:0]          sub_cr_dst,
    output logic [INDEX_W-1:0]  sub_index,
    output logic                sub_abort,
    input  logic                sub_busy,
    input  logic                sub_done,
    input  logic                sub_fault,
    input  fault_type_t         sub_fault_type
);

    localparam int         CNT_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] DEST_BASE4 = 4'(DEST_BASE);
    localparam logic [4:0] NUM_SRC5   = 5'(NUM_SRC_CR);

    localparam logic [2:0] CAUSE_NONE   = 3'd0;
    localparam logic [2:0] CAUSE_SRC    = 3'd1;
    localparam logic [2:0] CAUSE_NO_L   = 3'd2;
    localparam logic [2:0] CAUSE_TGT    = 3'd3;
    localparam logic [2:0] CAUSE_SUB    = 3'd4;
    localparam logic [2:0] CAUSE_TMO    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ_SRC,
        S_CHECK_PERM,
        S_READ_DST,
        S_START_SUB,
        S_WAIT_ACK,
        S_CALL_SUB
    } state_t;

    state_t              state, state_n;
    logic [3:0]          cmd_src;
    logic [TARGET_W-1:0] cmd_target;
    logic [INDEX_W-1:0]  cmd_index;
    logic [3:0]          cmd_dst;
    logic                src_l;
    logic                dst_pend;
    logic [CNT_W-1:0]    wd_cnt;

    logic                flt_det;
    logic [2:0]          flt_cause_n;
    fault_type_t         flt_type_n;
    logic                done_ok;
    logic                tmo_abort;
    logic                src_bad;
    logic                tgt_off;
    logic                wd_expired;

    assign src_bad    = ({1'b0, cmd_src} >= NUM_SRC5);
    assign tgt_off    = ~TARGET_EN_MASK[cmd_target];
    assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYC));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and fault/complete/abort decisions; a sub done or fault beats a same-cycle timeout
    always_comb begin
        state_n     = state;
        flt_det     = 1'b0;
        flt_cause_n = CAUSE_NONE;
        flt_type_n  = FAULT_NONE;
        done_ok     = 1'b0;
        tmo_abort   = 1'b0;
        case (state)
            S_IDLE: begin
                if (switch_start) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (src_bad) begin
                    flt_det     = 1'b1;
                    flt_cause_n = CAUSE_SRC;
                    flt_type_n  = FAULT_PERM;
                    state_n     = S_IDLE;
                end else if (tgt_off) begin
                    flt_det     = 1'b1;
                    flt_cause_n = CAUSE_TGT;
                    flt_type_n  = FAULT_PERM;
                    state_n     = S_IDLE;
                end else begin
                    state_n = S_READ_SRC;
                end
            end
            S_READ_SRC: state_n = S_CHECK_PERM;
            S_CHECK_PERM: begin
                if (!src_l) begin
                    flt_det     = 1'b1;
                    flt_cause_n = CAUSE_NO_L;
                    flt_type_n  = FAULT_PERM;
                    state_n     = S_IDLE;
                end else if (SAVE_PREV) begin
                    state_n = S_READ_DST;
                end else begin
                    state_n = S_START_SUB;
                end
            end
            S_READ_DST:  state_n = S_START_SUB;
            S_START_SUB: state_n = S_WAIT_ACK;
            S_WAIT_ACK, S_CALL_SUB: begin
                if (sub_fault) begin
                    flt_det     = 1'b1;
                    flt_cause_n = CAUSE_SUB;
                    flt_type_n  = sub_fault_type;
                    state_n     = S_IDLE;
                end else if (sub_done) begin
                    done_ok = 1'b1;
                    state_n = S_IDLE;
                end else if (wd_expired) begin
                    tmo_abort   = 1'b1;
                    flt_det     = 1'b1;
                    flt_cause_n = CAUSE_TMO;
                    flt_type_n  = TIMEOUT_FAULT;
                    state_n     = S_IDLE;
                end else if (state == S_WAIT_ACK && sub_busy) begin
                    state_n = S_CALL_SUB;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs decoded from state and the latched command
    always_comb begin
        switch_busy     = (state != S_IDLE);
        switch_complete = done_ok;
        sub_abort       = tmo_abort;
        start_dropped   = switch_start && (state != S_IDLE);
        sub_start       = (state == S_START_SUB) || (state == S_WAIT_ACK);
        cr_rd_addr      = (state == S_READ_DST) ? cmd_dst : cmd_src;
        sub_cr_src      = cmd_src;
        sub_cr_dst      = cmd_dst;
        sub_index       = cmd_index;
    end

    // Command capture on accept; sticky fault report cleared only by the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_src      <= '0;
            cmd_target   <= '0;
            cmd_index    <= '0;
            cmd_dst      <= '0;
            switch_fault <= 1'b0;
            fault_type   <= FAULT_NONE;
            fault_cause  <= CAUSE_NONE;
        end else if (state == S_IDLE && switch_start) begin
            cmd_src      <= cr_src;
            cmd_target   <= target;
            cmd_index    <= index;
            cmd_dst      <= DEST_BASE4 + 4'(target);
            switch_fault <= 1'b0;
            fault_type   <= FAULT_NONE;
            fault_cause  <= CAUSE_NONE;
        end else if (flt_det) begin
            switch_fault <= 1'b1;
            fault_type   <= flt_type_n;
            fault_cause  <= flt_cause_n;
        end
    end

    // L-permission capture: the source address has been on the read port since CHECK, so data is current in READ_SRC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_l <= 1'b0;
        end else if (state == S_READ_SRC) begin
            src_l <= cr_rd_data.word0_gt[48 + PERM_L];
        end
    end

    // Destination snapshot: the read port returns the READ_DST address one cycle later, so capture then
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_pend   <= 1'b0;
            prev_cap   <= '0;
            prev_valid <= 1'b0;
        end else begin
            dst_pend   <= (state == S_READ_DST);
            prev_valid <= dst_pend;
            if (dst_pend) prev_cap <= cr_rd_data;
        end
    end

    // Watchdog: cleared entering WAIT_ACK, counts every cycle in WAIT_ACK/CALL_SUB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == S_START_SUB) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT_ACK || state == S_CALL_SUB) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ctmm_switch_gen.sv
// Bench for ctmm_switch_gen: table of commands with a scripted mLoad responder, plus hand sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_ctmm_switch_gen;
    import ctmm_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            switch_start;
    logic [3:0]      cr_src;
    logic [2:0]      target;
    logic [9:0]      index;
    logic            switch_busy, switch_complete, switch_fault, start_dropped;
    fault_type_t     fault_type;
    logic [2:0]      fault_cause;
    logic [3:0]      cr_rd_addr;
    capability_reg_t cr_rd_data = '0;
    capability_reg_t prev_cap;
    logic            prev_valid, sub_start, sub_abort;
    logic [3:0]      sub_cr_src, sub_cr_dst;
    logic [9:0]      sub_index;
    logic            sub_busy, sub_done, sub_fault;
    fault_type_t     sub_fault_type;

    always #5 clk = ~clk;

    ctmm_switch_gen #(
        .NUM_SRC_CR(8), .TARGET_W(3), .DEST_BASE(8), .TARGET_EN_MASK(8'h81),
        .INDEX_W(10), .SAVE_PREV(1'b1), .TIMEOUT_CYC(16), .TIMEOUT_FAULT(FAULT_TYPE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .switch_start(switch_start), .cr_src(cr_src),
        .target(target), .index(index), .switch_busy(switch_busy),
        .switch_complete(switch_complete), .switch_fault(switch_fault),
        .fault_type(fault_type), .fault_cause(fault_cause), .start_dropped(start_dropped),
        .cr_rd_addr(cr_rd_addr), .cr_rd_data(cr_rd_data), .prev_cap(prev_cap),
        .prev_valid(prev_valid), .sub_start(sub_start), .sub_cr_src(sub_cr_src),
        .sub_cr_dst(sub_cr_dst), .sub_index(sub_index), .sub_abort(sub_abort),
        .sub_busy(sub_busy), .sub_done(sub_done), .sub_fault(sub_fault),
        .sub_fault_type(sub_fault_type)
    );

    // Register file model with one-cycle read latency
    capability_reg_t regs [16];
    always @(posedge clk) cr_rd_data <= regs[cr_rd_addr];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int vec, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [vec %0d]: got 0x%0h, expected 0x%0h", name, vec, act, exp);
        end
    endtask

    // endk: 0 done, 1 fault, 2 done+fault, 3 never finishes
    typedef struct {
        int src; int tgt; int idx; int lbit; int ack; int run; int endk;
        int e_cause; fault_type_t e_type; int e_ss; int e_cmpl; int e_abort; int e_idle;
    } vec_t;
    vec_t vt [11];

    task automatic run_vec(input int v);
        int s = -1, t, end_c = -1, first_ss = -1, cmpl_cyc = -1, n_cmpl = 0;
        int abort_cyc = -1, n_abort = 0, pv_cyc = -1, n_pv = 0;
        logic fin;
        logic clr_flag = 1'b1;
        capability_reg_t pv_val = '0;
        logic [3:0] ss_dst = '0, ss_src = '0;
        logic [9:0] ss_idx = '0;
        logic [3:0] dst = 4'(8 + vt[v].tgt);
        regs[vt[v].src].word0_gt[48 + PERM_L] = (vt[v].lbit != 0);
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            switch_start = (c == 0);
            cr_src = 4'(vt[v].src);
            target = 3'(vt[v].tgt);
            index  = 10'(vt[v].idx);
            t   = (s < 0) ? -1 : c - s;
            fin = (s >= 0) && (t == vt[v].ack + vt[v].run);
            sub_busy  = (s >= 0) && (t >= vt[v].ack) && (t <= vt[v].ack + vt[v].run);
            sub_done  = fin && (vt[v].endk == 0 || vt[v].endk == 2);
            sub_fault = fin && (vt[v].endk == 1 || vt[v].endk == 2);
            sub_fault_type = sub_fault ? FAULT_BOUNDS : FAULT_NONE;
            @(negedge clk);
            if (c == 1) clr_flag = switch_fault;
            if (sub_start && first_ss < 0) begin
                first_ss = c; s = c;
                ss_dst = sub_cr_dst; ss_src = sub_cr_src; ss_idx = sub_index;
            end
            if (switch_complete) begin n_cmpl++; cmpl_cyc = c; end
            if (sub_abort) begin n_abort++; abort_cyc = c; end
            if (prev_valid) begin n_pv++; pv_cyc = c; pv_val = prev_cap; end
            if (c > 0 && !switch_busy) begin end_c = c; break; end
        end
        @(posedge clk); #1;
        switch_start = 1'b0; sub_busy = 1'b0; sub_done = 1'b0; sub_fault = 1'b0;
        sub_fault_type = FAULT_NONE;
        check("fault_cleared_on_accept", v, 128'(clr_flag), 128'(0));
        check("idle_cycle", v, 128'(end_c), 128'(vt[v].e_idle));
        check("switch_fault", v, 128'(switch_fault), 128'(vt[v].e_cause != 0));
        check("fault_cause", v, 128'(fault_cause), 128'(vt[v].e_cause));
        check("fault_type", v, 128'(fault_type), 128'(vt[v].e_type));
        check("sub_start_cycle", v, 128'(first_ss), 128'(vt[v].e_ss));
        check("complete_cycle", v, 128'(cmpl_cyc), 128'(vt[v].e_cmpl));
        check("complete_count", v, 128'(n_cmpl), 128'(vt[v].e_cmpl >= 0));
        check("abort_cycle", v, 128'(abort_cyc), 128'(vt[v].e_abort));
        check("abort_count", v, 128'(n_abort), 128'(vt[v].e_abort >= 0));
        if (vt[v].e_ss >= 0) begin
            check("sub_cr_dst", v, 128'(ss_dst), 128'(dst));
            check("sub_cr_src", v, 128'(ss_src), 128'(vt[v].src));
            check("sub_index", v, 128'(ss_idx), 128'(vt[v].idx));
            check("prev_valid_cycle", v, 128'(pv_cyc), 128'(6));
            check("prev_cap", v, 128'(pv_val), 128'(regs[dst]));
        end
        check("prev_valid_count", v, 128'(n_pv), 128'(vt[v].e_ss >= 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("fault_sticky", v, 128'(switch_fault), 128'(vt[v].e_cause != 0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, got %0d checks", n_checks);
        $fatal(1);
    end

    initial begin
        int nd, end_c;
        for (int i = 0; i < 16; i++)
            regs[i] = '{word0_gt: 64'h0000_ABCD_0000_0000 | 64'(i), word1: 32'hC0DE_0000 | 32'(i)};

        //          src tgt idx  L ack run endk cause type          ss cmpl abort idle
        vt[0]  = '{2,  0, 5,    1, 2, 10, 0,   0, FAULT_NONE,   5, 17, -1, 18};
        vt[1]  = '{9,  0, 5,    1, 0, 0,  0,   1, FAULT_PERM,  -1, -1, -1,  2};
        vt[2]  = '{1,  0, 7,    1, 1, 3,  0,   0, FAULT_NONE,   5,  9, -1, 10};
        vt[3]  = '{3,  0, 0,    0, 0, 0,  0,   2, FAULT_PERM,  -1, -1, -1,  4};
        vt[4]  = '{4,  3, 2,    1, 0, 0,  0,   3, FAULT_PERM,  -1, -1, -1,  2};
        vt[5]  = '{5,  7, 1023, 1, 2, 4,  1,   4, FAULT_BOUNDS, 5, -1, -1, 12};
        vt[6]  = '{0,  7, 512,  1, 2, 4,  2,   4, FAULT_BOUNDS, 5, -1, -1, 12};
        vt[7]  = '{7,  0, 3,    1, 1, 1,  0,   0, FAULT_NONE,   5,  7, -1,  8};
        vt[8]  = '{8,  0, 6,    1, 0, 0,  0,   1, FAULT_PERM,  -1, -1, -1,  2};
        vt[9]  = '{2,  0, 9,    1, 1, 100, 3,  5, FAULT_TYPE,   5, -1, 22, 23};
        vt[10] = '{6,  0, 4,    1, 1, 16, 0,   0, FAULT_NONE,   5, 22, -1, 23};

        rst_n = 1'b0; switch_start = 1'b0; cr_src = '0; target = '0; index = '0;
        sub_busy = 1'b0; sub_done = 1'b0; sub_fault = 1'b0; sub_fault_type = FAULT_NONE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", -1, 128'(switch_busy), 128'(0));
        check("rst_fault", -1, 128'(switch_fault), 128'(0));
        check("rst_cause", -1, 128'(fault_cause), 128'(0));
        check("rst_type", -1, 128'(fault_type), 128'(FAULT_NONE));
        check("rst_sub_start", -1, 128'(sub_start), 128'(0));
        check("rst_prev_cap", -1, 128'(prev_cap), 128'(0));
        check("rst_sub_cr_dst", -1, 128'(sub_cr_dst), 128'(0));
        check("rst_cr_rd_addr", -1, 128'(cr_rd_addr), 128'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        for (int v = 0; v < 11; v++) run_vec(v);

        // Dropped starts: 3-cycle start pulse while busy, mLoad never acks
        regs[2].word0_gt[48 + PERM_L] = 1'b1;
        nd = 0; end_c = -1;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            switch_start = (c == 0) || (c >= 3 && c <= 5);
            cr_src = 4'd2; target = 3'd0; index = 10'd11;
            @(negedge clk);
            if (start_dropped) nd++;
            if (c > 0 && !switch_busy) begin end_c = c; break; end
        end
        @(posedge clk); #1 switch_start = 1'b0;
        check("dropped_count", 100, 128'(nd), 128'(3));
        check("dropped_idle_cycle", 100, 128'(end_c), 128'(23));
        check("dropped_cause", 100, 128'(fault_cause), 128'(5));
        @(negedge clk);
        check("dropped_not_queued", 100, 128'(switch_busy), 128'(0));

        // Reset while in CALL_SUB
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            switch_start = (c == 0);
            cr_src = 4'd2; target = 3'd0; index = 10'd1;
            sub_busy = (c >= 6);
        end
        #2;
        check("pre_rst_busy", 101, 128'(switch_busy), 128'(1));
        check("pre_rst_prev_cap", 101, 128'(prev_cap), 128'(regs[8]));
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 101, 128'(switch_busy), 128'(0));
        check("mid_rst_prev_cap", 101, 128'(prev_cap), 128'(0));
        check("mid_rst_prev_valid", 101, 128'(prev_valid), 128'(0));
        check("mid_rst_fault", 101, 128'(switch_fault), 128'(0));
        check("mid_rst_abort", 101, 128'(sub_abort), 128'(0));
        check("mid_rst_sub_start", 101, 128'(sub_start), 128'(0));
        check("mid_rst_sub_cr_dst", 101, 128'(sub_cr_dst), 128'(0));
        @(posedge clk); #1;
        sub_busy = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 101, 128'(switch_busy), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ctmm_switch_gen.md
Name: ctmm_switch_gen

Overview:
- Parametrised successor to the fixed SWITCH (CR8–CR15) instruction sequencer.
- Validates the source C-List register, checks for L permission and optionally snapshots the current destination register for CHANGE/return bookkeeping.
- Invokes the shared mLoad micro-routine through an exposed subroutine handshake, with a watchdog and abort.
- Sits between the Church instruction decoder and ctmm_mload; register file and mLoad are external.

Parameters:
- NUM_SRC_CR, 8: sources CR0..NUM_SRC_CR-1 legal (1..15).
- TARGET_W, 3: target field width; dest = DEST_BASE + target.
- DEST_BASE, 8: first system register.
- TARGET_EN_MASK, 8'hFF: bit t=1 means target t is enabled. Width 2**TARGET_W.
- INDEX_W, 10: C-List index width.
- SAVE_PREV, 1: read and present the old destination value before mLoad.
- TIMEOUT_CYC, 1024: watchdog limit in cycles, ≥2. Counter width $clog2(TIMEOUT_CYC+1).
- TIMEOUT_FAULT, FAULT_PERM: fault_type_t reported on timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- switch_start  in  1  command request (level, sampled in IDLE)
- cr_src  in  4  source CR
- target  in  TARGET_W  target field
- index  in  INDEX_W  C-List index
- switch_busy  out  1  state != IDLE
- switch_complete  out  1  one-cycle success pulse
- switch_fault  out  1  sticky fault flag
- fault_type  out  fault_type_t  latched fault type
- fault_cause  out  3  0 none, 1 src range, 2 no L, 3 target disabled, 4 sub fault, 5 timeout
- start_dropped  out  1  pulse: switch_start seen while busy
- cr_rd_addr  out  4  register read address
- cr_rd_data  in  capability_reg_t  read data, 1-cycle latency
- prev_cap  out  capability_reg_t  snapshot of old destination
- prev_valid  out  1  one-cycle pulse when prev_cap updated
- sub_start  out  1  mLoad request
- sub_cr_src  out  4  to mLoad
- sub_cr_dst  out  4  to mLoad
- sub_index  out  INDEX_W  to mLoad
- sub_abort  out  1  one-cycle abort pulse on timeout
- sub_busy  in  1  from mLoad
- sub_done  in  1  from mLoad
- sub_fault  in  1  from mLoad
- sub_fault_type  in  fault_type_t  from mLoad

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; all outputs 0 / FAULT_NONE; prev_cap '0; latched command '0.
- Command capture: in IDLE with switch_start=1, latch cr_src, target and index. Clear switch_fault, fault_type and fault_cause. Move to CHECK.
- Sub outputs: sub_cr_src, sub_cr_dst and sub_index come from the latched command only and are stable for the whole command.
- Destination: dest = DEST_BASE + zero-extended target, computed modulo 16.
- CHECK:
  - If cr_src ≥ NUM_SRC_CR: fault cause 1.
  - Else if TARGET_EN_MASK[target]=0: fault cause 3.
  - Else go to READ_SRC with cr_rd_addr = cr_src.
- READ_SRC: drive cr_rd_addr = cr_src. Latch cr_rd_data at the end of the cycle, then go to CHECK_PERM.
- CHECK_PERM: L permission is word0_gt[48+PERM_L] of the latched data.
  - If clear: fault cause 2.
  - Else if SAVE_PREV: go to READ_DST.
  - Else: go to START_SUB.
- READ_DST: drive cr_rd_addr = dest. Latch into prev_cap; prev_valid pulses the following cycle. Go to START_SUB.
- START_SUB: sub_start=1, go to WAIT_ACK.
- WAIT_ACK: hold sub_start=1 until sub_busy=1, then go to CALL_SUB.
- CALL_SUB: wait for mLoad to finish.
  - sub_done: switch_complete=1 in the same cycle, then IDLE.
  - sub_fault: fault cause 4 with fault_type = sub_fault_type, then IDLE.
  - If sub_done and sub_fault are both high, fault wins and there is no complete pulse.
- Watchdog:
  - Counter clears on entry to WAIT_ACK and increments each cycle spent in WAIT_ACK or CALL_SUB.
  - Timeout occurs when the counter reaches TIMEOUT_CYC with no done or fault.
  - On timeout: sub_abort pulses for one cycle, fault cause 5 with fault_type = TIMEOUT_FAULT, state goes to IDLE.
  - A done or fault arriving in the same cycle as the timeout wins.
- Faults:
  - Causes 1, 2 and 3 report fault_type = FAULT_PERM.
  - Every fault sets switch_fault=1 from the cycle after detection, returns to IDLE, and holds until the next accepted start.
- Register read address: when not in READ_SRC or READ_DST, cr_rd_addr = cr_src (latched). It is a don't-care for the register file.
- Latency without faults (SAVE_PREV=0): start sampled at cycle 0; sub_start first asserted at cycle 4. SAVE_PREV=1 adds 1 cycle.
- Back-to-back: a new start can be accepted the cycle after returning to IDLE.
- Dropped starts: switch_start while busy pulses start_dropped for each such cycle. The command is not queued.
- Reset mid-operation returns immediately to IDLE with all outputs cleared. No sub_abort is generated; mLoad shares rst_n.

Test Plan:
- Basic load: cr_src=2, target=0, index=5, L set, SAVE_PREV=1. mLoad acks after 2 cycles and is done 10 cycles later. Expect sub_cr_dst=8, prev_valid pulse with CR8's prior contents, switch_complete for 1 cycle, no fault.
- Source out of range: cr_src=9 with NUM_SRC_CR=8. Expect switch_fault=1 with cause 1 (FAULT_PERM), sub_start never asserted. Then the same command with cr_src=1 and L set completes.
- Missing L: L bit cleared. Expect cause 2, fault_type FAULT_PERM, no sub_start. Separately, TARGET_EN_MASK=8'h81 with target=3: expect cause 3.
- Sub fault: mLoad asserts sub_fault with FAULT_BOUNDS, also with sub_done in the same cycle. Expect cause 4, fault_type FAULT_BOUNDS, no complete pulse.
- Watchdog: TIMEOUT_CYC=16, sub_busy=1 and never done. Expect a sub_abort pulse 16 cycles after WAIT_ACK entry and cause 5. With sub_done arriving on cycle 16, expect complete and no abort.
- Collisions and reset: a 3-cycle switch_start pulse while busy gives 3 start_dropped pulses. Asserting rst_n=0 in CALL_SUB clears busy, faults and prev_valid asynchronously.
